vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/VESA timing generator, successor to the fixed 640x480 vga_controller.
//  Resolution, porches, sync widths and sync polarities are parameters.
//  Adds a pixel-enable input for sub-rate pixel clocks, and a PIPE_DELAY shift register
//  that aligns the sync/blank outputs with a pipelined image generator.
//  Adds line_start and frame_start pulses.
//  Sits between the pixel-clock source and the image generator / DAC pins.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels), >=1
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines), >=1
//  V_BP       33   vertical back porch (lines)
//  H_POL      0    h_sync asserted level (0 = active-low pulse)
//  V_POL      0    v_sync asserted level
//  CNT_W      11   width of counters, column and row; must hold H_TOTAL-1 and V_TOTAL-1
//  PIPE_DELAY 0    extra output delay in pix_en-qualified cycles (0..15)
// PORTS
//  pixel_clk    in   1      pixel clock, all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  pix_en       in   1      advance enable; when 0, all state holds
//  h_sync       out  1      horizontal sync, level per H_POL
//  v_sync       out  1      vertical sync, level per V_POL
//  disp_ena     out  1      1 inside the active region
//  column       out  CNT_W  pixel x when disp_ena=1, else 0
//  row          out  CNT_W  pixel y when disp_ena=1, else 0
//  n_blank      out  1      equals disp_ena
//  n_sync       out  1      constant 0 (no sync-on-green)
//  line_start   out  1      1-clk pulse at h_cnt==0 of every line
//  frame_start  out  1      1-clk pulse at h_cnt==0, v_cnt==0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - h_cnt counts 0..H_TOTAL-1 on each pix_en and wraps to 0.
//  - v_cnt increments only when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
//  - Decode from the current counters:
//    - act = (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE)
//    - hs asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
//    - vs asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; vs is a full-line
//      quantity, so it changes at h_cnt==0
//  - The decode is registered into stage 0, then passes through PIPE_DELAY further stages
//    {hs,vs,act,col,row,ls,fs}.
//  - Each stage loads only on pix_en=1.
//  - Output latency: 1+PIPE_DELAY pix_en cycles from a counter value to its outputs.
//  - line_start/frame_start are high for exactly one pixel_clk cycle: the cycle after the
//    pix_en edge that loads a ls/fs-tagged entry into the final stage.
//    - They are 0 in every other cycle, including held cycles with pix_en=0.
//  - Reset: counters=0, all stages flushed to inactive.
//    - h_sync=~H_POL, v_sync=~V_POL
//    - disp_ena=0, n_blank=0, column=0, row=0
//    - line_start=0, frame_start=0, n_sync=0
//  - Reset mid-frame: takes effect on the next edge, with no partial line.
//    - First output after release is (0,0) with frame_start=1, after 1+PIPE_DELAY enables.
//  - Reset dominates pix_en.
//  - pix_en=0 for any duration: outputs hold their last value, and no pulse repeats.
//  - Counter wrap and v_cnt wrap on the same cycle: both counters go to 0 together.
// TESTING
//  1. reset=1 for 3 clks, defaults -> h_sync=1, v_sync=1, disp_ena=0, column=row=0,
//     pulses=0.
//  2. Defaults, pix_en=1, PIPE_DELAY=0, cycle 1 = first after reset release ->
//     frame_start=1 at cycle 1; disp_ena=1 for cycles 1..640, column 0..639;
//     h_sync=0 for cycles 657..752; line period 800 clks.
//  3. Full frame, defaults -> 525 line_start pulses, one frame_start;
//     v_sync=0 for lines 490..491; row max 479.
//  4. PIPE_DELAY=3, pix_en=1 -> every output sequence equals case 2 shifted +3 clks.
//  5. pix_en toggling 1,0 -> counters and outputs advance every 2nd clk;
//     line_start is one clk wide; line period 1600 clks.
//  6. Assert reset at line 200, column 300, for 1 clk -> outputs at reset values
//     next cycle; frame_start after 1+PIPE_DELAY enables; row/column restart at 0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and the image path / DAC pins.
// The master side drives the sync, blank, position and pulse signals and receives pix_en.
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             pix_en;
  logic             h_sync;
  logic             v_sync;
  logic             disp_ena;
  logic [CNT_W-1:0] column;
  logic [CNT_W-1:0] row;
  logic             n_blank;
  logic             n_sync;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pix_en,
    output h_sync, v_sync, disp_ena, column, row, n_blank, n_sync, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  h_sync, v_sync, disp_ena, column, row, n_blank, n_sync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator with a pixel-enable input and an optional
// output delay line that keeps sync/blank aligned with a pipelined image generator.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int CNT_W      = 11,
  parameter int PIPE_DELAY = 0
) (
  input  logic                pixel_clk,
  input  logic                reset,
  vga_timing_gen_if.master    vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // hs/vs are stored at their pin level so the delay line needs no polarity logic.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             act;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             ls;
    logic             fs;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{
    hs:  ~H_POL,
    vs:  ~V_POL,
    act: 1'b0,
    col: '0,
    row: '0,
    ls:  1'b0,
    fs:  1'b0
  };

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_fresh;

  logic             w_act;
  logic             w_hs_on;
  logic             w_vs_on;
  stage_t           w_decode;

  stage_t           r_stage    [PIPE_DELAY+1];
  stage_t           w_stage_in [PIPE_DELAY+1];

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (vga.pix_en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  assign w_act   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_on = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_on = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

  always_comb begin
    w_decode     = STAGE_IDLE;
    w_decode.hs  = w_hs_on ? H_POL : ~H_POL;
    w_decode.vs  = w_vs_on ? V_POL : ~V_POL;
    w_decode.act = w_act;
    w_decode.col = w_act ? r_h_cnt : '0;
    w_decode.row = w_act ? r_v_cnt : '0;
    w_decode.ls  = (r_h_cnt == '0);
    w_decode.fs  = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi <= PIPE_DELAY; gi++) begin : g_stage_in
      if (gi == 0) begin : g_head
        assign w_stage_in[gi] = w_decode;
      end else begin : g_tail
        assign w_stage_in[gi] = r_stage[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        r_stage[i] <= STAGE_IDLE;
      end
    end else if (vga.pix_en) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        r_stage[i] <= w_stage_in[i];
      end
    end
  end

  // Pulses are qualified by "the last edge was an enabled one", so held cycles never repeat them.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= vga.pix_en;
    end
  end

  assign vga.h_sync      = r_stage[PIPE_DELAY].hs;
  assign vga.v_sync      = r_stage[PIPE_DELAY].vs;
  assign vga.disp_ena    = r_stage[PIPE_DELAY].act;
  assign vga.n_blank     = r_stage[PIPE_DELAY].act;
  assign vga.column      = r_stage[PIPE_DELAY].col;
  assign vga.row         = r_stage[PIPE_DELAY].row;
  assign vga.n_sync      = 1'b0;
  assign vga.line_start  = r_fresh & r_stage[PIPE_DELAY].ls;
  assign vga.frame_start = r_fresh & r_stage[PIPE_DELAY].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instances (delay 0 and 3) plus a tiny-raster
// instance with positive sync polarity, all checked against a queued behavioural model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [10:0] col;
    logic [10:0] row;
    logic        ls;
    logic        fs;
  } exp_t;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b1;
  logic pix_en    = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen_if #(.CNT_W(11)) if_a ();
  vga_timing_gen_if #(.CNT_W(11)) if_b ();
  vga_timing_gen_if #(.CNT_W(11)) if_c ();

  assign if_a.pix_en = pix_en;
  assign if_b.pix_en = pix_en;
  assign if_c.pix_en = pix_en;

  vga_timing_gen #(.PIPE_DELAY(0)) dut_a (
    .pixel_clk(pixel_clk), .reset(reset), .vga(if_a)
  );

  vga_timing_gen #(.PIPE_DELAY(3)) dut_b (
    .pixel_clk(pixel_clk), .reset(reset), .vga(if_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(11), .PIPE_DELAY(2)
  ) dut_c (
    .pixel_clk(pixel_clk), .reset(reset), .vga(if_c)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;
  int   m_h, m_v, s_h, s_v;

  function automatic exp_t dec(input int h, input int v, input int ha, input int hf, input int hs,
                               input int va, input int vf, input int vs, input bit hp, input bit vp);
    exp_t e;
    bit   act;
    act   = (h < ha) && (v < va);
    e.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    e.vs  = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    e.act = act;
    e.col = act ? 11'(h) : 11'd0;
    e.row = act ? 11'(v) : 11'd0;
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t idle(input bit hp, input bit vp);
    exp_t e;
    e    = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    return e;
  endfunction

  function automatic exp_t obs_a();
    return {if_a.h_sync, if_a.v_sync, if_a.disp_ena, if_a.column, if_a.row, if_a.line_start, if_a.frame_start};
  endfunction

  function automatic exp_t obs_b();
    return {if_b.h_sync, if_b.v_sync, if_b.disp_ena, if_b.column, if_b.row, if_b.line_start, if_b.frame_start};
  endfunction

  function automatic exp_t obs_c();
    return {if_c.h_sync, if_c.v_sync, if_c.disp_ena, if_c.column, if_c.row, if_c.line_start, if_c.frame_start};
  endfunction

  // One clock: drive inputs, advance the model, push the new decode and pop what each
  // delay line is now presenting.
  task automatic tick(input bit rst, input bit en);
    exp_t d;
    reset  = rst;
    pix_en = en;
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (rst) begin
      q_a.delete(); q_b.delete(); q_c.delete();
      m_h = 0; m_v = 0; s_h = 0; s_v = 0;
      e_a = idle(1'b0, 1'b0);
      e_b = idle(1'b0, 1'b0);
      e_c = idle(1'b1, 1'b1);
    end else begin
      e_a.ls = 1'b0; e_a.fs = 1'b0;
      e_b.ls = 1'b0; e_b.fs = 1'b0;
      e_c.ls = 1'b0; e_c.fs = 1'b0;
      if (en) begin
        d = dec(m_h, m_v, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
        q_a.push_back(d);
        q_b.push_back(d);
        q_c.push_back(dec(s_h, s_v, 8, 2, 3, 6, 2, 2, 1'b1, 1'b1));
        m_h++;
        if (m_h == 800) begin m_h = 0; m_v++; if (m_v == 525) m_v = 0; end
        s_h++;
        if (s_h == 15) begin s_h = 0; s_v++; if (s_v == 13) s_v = 0; end
        if (q_a.size() > 0) e_a = q_a.pop_front();
        if (q_b.size() > 3) e_b = q_b.pop_front();
        if (q_c.size() > 2) e_c = q_c.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    exp_t r;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    r = '0; r.hs = 1'b1; r.vs = 1'b1;
    total++;
    if (obs_a() !== r) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a(), r); end
    total++;
    if (obs_b() !== r) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b(), r); end
    r = '0;
    total++;
    if (obs_c() !== r) begin bad++; $display("FAIL reset_c got=%h exp=%h", obs_c(), r); end
    total++;
    if (if_a.n_blank !== 1'b0 || if_a.n_sync !== 1'b0) begin
      bad++; $display("FAIL reset_nblank_nsync got=%b%b exp=00", if_a.n_blank, if_a.n_sync);
    end
  endtask

  task automatic test_line_timing();
    int hs_first = -1, hs_last = -1, ls2 = -1, act_cnt = 0, last_col = -1;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    for (int c = 1; c <= 1700; c++) begin
      tick(1'b0, 1'b1);
      total++;
      if (obs_a() !== e_a) begin bad++; $display("FAIL line_seq c=%0d got=%h exp=%h", c, obs_a(), e_a); end
      total++;
      if (if_a.n_blank !== e_a.act || if_a.n_sync !== 1'b0) begin
        bad++; $display("FAIL line_nblank c=%0d got=%b%b exp=%b0", c, if_a.n_blank, if_a.n_sync, e_a.act);
      end
      if (c == 1) begin
        total++;
        if (if_a.frame_start !== 1'b1 || if_a.disp_ena !== 1'b1 || if_a.column !== 11'd0) begin
          bad++; $display("FAIL line_first fs=%b ena=%b col=%0d exp fs=1 ena=1 col=0",
                          if_a.frame_start, if_a.disp_ena, if_a.column);
        end
      end
      if (c <= 800) begin
        if (if_a.disp_ena === 1'b1) begin act_cnt++; last_col = int'(if_a.column); end
        if (if_a.h_sync === 1'b0) begin if (hs_first < 0) hs_first = c; hs_last = c; end
      end
      if (c > 1 && if_a.line_start === 1'b1 && ls2 < 0) ls2 = c;
    end
    total++;
    if (act_cnt != 640 || last_col != 639) begin
      bad++; $display("FAIL line_active cnt=%0d last_col=%0d exp 640 639", act_cnt, last_col);
    end
    total++;
    if (hs_first != 657 || hs_last != 752) begin
      bad++; $display("FAIL line_hsync first=%0d last=%0d exp 657 752", hs_first, hs_last);
    end
    total++;
    if (ls2 != 801) begin bad++; $display("FAIL line_period second_ls=%0d exp 801", ls2); end
  endtask

  task automatic test_pipe_delay();
    int fs_first = -1, hs_first = -1, hs_last = -1, act_first = -1, act_cnt = 0;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    for (int c = 1; c <= 820; c++) begin
      tick(1'b0, 1'b1);
      total++;
      if (obs_b() !== e_b) begin bad++; $display("FAIL pipe_seq c=%0d got=%h exp=%h", c, obs_b(), e_b); end
      if (if_b.frame_start === 1'b1 && fs_first < 0) fs_first = c;
      if (c <= 803) begin
        if (if_b.disp_ena === 1'b1) begin act_cnt++; if (act_first < 0) act_first = c; end
        if (if_b.h_sync === 1'b0) begin if (hs_first < 0) hs_first = c; hs_last = c; end
      end
    end
    total++;
    if (fs_first != 4 || act_first != 4 || act_cnt != 640) begin
      bad++; $display("FAIL pipe_shift fs=%0d act_first=%0d act_cnt=%0d exp 4 4 640", fs_first, act_first, act_cnt);
    end
    total++;
    if (hs_first != 660 || hs_last != 755) begin
      bad++; $display("FAIL pipe_hsync first=%0d last=%0d exp 660 755", hs_first, hs_last);
    end
  endtask

  task automatic test_frame();
    int ls_cnt = 0, fs_cnt = 0, vs_cnt = 0, row_max = -1, fs_second = -1;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    for (int c = 1; c <= 400; c++) begin
      tick(1'b0, 1'b1);
      total++;
      if (obs_c() !== e_c) begin bad++; $display("FAIL frame_seq c=%0d got=%h exp=%h", c, obs_c(), e_c); end
      if (c >= 3 && c <= 197) begin
        if (if_c.line_start === 1'b1) ls_cnt++;
        if (if_c.frame_start === 1'b1) fs_cnt++;
        if (if_c.v_sync === 1'b1) vs_cnt++;
        if (if_c.disp_ena === 1'b1 && int'(if_c.row) > row_max) row_max = int'(if_c.row);
      end
      if (c > 3 && if_c.frame_start === 1'b1 && fs_second < 0) fs_second = c;
    end
    total++;
    if (ls_cnt != 13 || fs_cnt != 1) begin
      bad++; $display("FAIL frame_pulses ls=%0d fs=%0d exp 13 1", ls_cnt, fs_cnt);
    end
    total++;
    if (vs_cnt != 30 || row_max != 5) begin
      bad++; $display("FAIL frame_vsync vs_cycles=%0d row_max=%0d exp 30 5", vs_cnt, row_max);
    end
    total++;
    if (fs_second != 198) begin bad++; $display("FAIL frame_period second_fs=%0d exp 198", fs_second); end
  endtask

  task automatic test_pix_en_toggle();
    int ls_first = -1, ls_second = -1, wide = 0;
    logic prev_ls = 1'b0;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    for (int c = 1; c <= 3300; c++) begin
      tick(1'b0, (c % 2) == 1);
      total++;
      if (obs_a() !== e_a || obs_b() !== e_b) begin
        bad++; $display("FAIL toggle_seq c=%0d got=%h/%h exp=%h/%h", c, obs_a(), obs_b(), e_a, e_b);
      end
      if (if_a.line_start === 1'b1) begin
        if (prev_ls === 1'b1) wide++;
        if (ls_first < 0) ls_first = c;
        else if (ls_second < 0) ls_second = c;
      end
      prev_ls = if_a.line_start;
    end
    total++;
    if (ls_first != 1 || ls_second != 1601 || wide != 0) begin
      bad++; $display("FAIL toggle_line ls1=%0d ls2=%0d wide=%0d exp 1 1601 0", ls_first, ls_second, wide);
    end
    for (int c = 0; c < 25; c++) begin
      tick(1'b0, 1'b0);
      total++;
      if (obs_a() !== e_a || obs_c() !== e_c) begin
        bad++; $display("FAIL hold_seq c=%0d got=%h/%h exp=%h/%h", c, obs_a(), obs_c(), e_a, e_c);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t r;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    for (int c = 1; c <= 1100; c++) begin
      tick(1'b0, 1'b1);
      total++;
      if (obs_a() !== e_a || obs_c() !== e_c) begin
        bad++; $display("FAIL mid_pre c=%0d got=%h/%h exp=%h/%h", c, obs_a(), obs_c(), e_a, e_c);
      end
    end
    tick(1'b1, 1'b1);
    r = '0; r.hs = 1'b1; r.vs = 1'b1;
    total++;
    if (obs_a() !== r) begin bad++; $display("FAIL mid_reset_a got=%h exp=%h", obs_a(), r); end
    r = '0;
    total++;
    if (obs_c() !== r) begin bad++; $display("FAIL mid_reset_c got=%h exp=%h", obs_c(), r); end
    for (int c = 1; c <= 10; c++) begin
      tick(1'b0, 1'b1);
      total++;
      if (obs_a() !== e_a || obs_c() !== e_c) begin
        bad++; $display("FAIL mid_post c=%0d got=%h/%h exp=%h/%h", c, obs_a(), obs_c(), e_a, e_c);
      end
      if (c == 1) begin
        total++;
        if (if_a.frame_start !== 1'b1 || if_a.column !== 11'd0 || if_a.row !== 11'd0 || if_c.frame_start !== 1'b0) begin
          bad++; $display("FAIL mid_restart_a fs=%b col=%0d row=%0d c_fs=%b exp 1 0 0 0",
                          if_a.frame_start, if_a.column, if_a.row, if_c.frame_start);
        end
      end
      if (c == 3) begin
        total++;
        if (if_c.frame_start !== 1'b1 || if_c.column !== 11'd0 || if_c.disp_ena !== 1'b1) begin
          bad++; $display("FAIL mid_restart_c fs=%b col=%0d ena=%b exp 1 0 1",
                          if_c.frame_start, if_c.column, if_c.disp_ena);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_pipe_delay();
    test_frame();
    test_pix_en_toggle();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
